// File: rtl/serial_sub_n.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop, LSB first.
// Defining SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
module serial_sub_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic fs_diff(input logic ai, input logic bi, input logic br);
        return ai ^ bi ^ br;
    endfunction

    function automatic logic fs_borrow(input logic ai, input logic bi, input logic br);
        return (~ai & bi) | (~(ai ^ bi) & br);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             bit_d_s;
    logic             bit_b_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; start is only looked at when not busy.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                    last_s      = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        bit_d_s = fs_diff(a_sh_r[0], b_sh_r[0], br_r);
        bit_b_s = fs_borrow(a_sh_r[0], b_sh_r[0], br_r);
    end

    // Operand shift registers; difference bits refill a_sh_r from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= CNT_ZERO;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sh_r <= a;
            b_sh_r <= b;
            br_r   <= bin;
            cnt_r  <= CNT_ZERO;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
`endif
        end else if (state_r == RUN) begin
            a_sh_r <= {bit_d_s, a_sh_r[WIDTH-1:1]};
            b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
            br_r   <= bit_b_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            a_sh_r <= a_sh_r;
            b_sh_r <= b_sh_r;
            br_r   <= br_r;
            cnt_r  <= cnt_r;
        end
    end

    // Registered outputs; results change only on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            diff <= {WIDTH{1'b0}};
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt_s == RUN);
            done <= last_s;
            if (last_s) begin
                diff <= {bit_d_s, a_sh_r[WIDTH-1:1]};
                bout <= bit_b_s;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ bit_d_s);
`endif
            end else begin
                diff <= diff;
                bout <= bout;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= ovf;
`endif
            end
        end
    end

endmodule

// File: doc/serial_sub_n.md
SERIAL_SUB_N -- requirements
Module: serial_sub_n

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request to begin one subtraction; sampled on the rising edge of clk.
REQ-005 SHALL have ports: a, b  input  WIDTH  minuend and subtrahend; sampled on the edge where start is accepted.
REQ-006 SHALL have port: bin  input  1  borrow-in; sampled with a and b.
REQ-007 SHALL have port: busy  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH.
REQ-010 SHALL have port: bout  output  1  borrow-out from the MSB.
REQ-011 SHALL have port: ovf  output  1  signed overflow; present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-012 SHALL implement a bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop, processing one bit per cycle, LSB first.
REQ-013 SHALL use per-bit equations: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-014 SHALL implement FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-015 SHALL accept start only when busy=0 (IDLE or DONE); on acceptance at edge E0 it latches a, b and bin, loads br=bin, clears the bit counter, and moves to RUN.
REQ-016 SHALL, in RUN, process bit k at edge E(k+1), for k = 0..WIDTH-1.
REQ-017 SHALL, at edge E_WIDTH, load diff and bout together from the internal shift register and borrow, and move to DONE.
REQ-018 SHALL hold busy=1 for exactly WIDTH cycles, from after E0 through E_WIDTH.
REQ-019 SHALL hold done=1 only during the cycle following E_WIDTH; the state then returns to IDLE, or goes back to RUN if start is high at that edge (back-to-back operation).
REQ-020 SHALL ignore start while busy=1: latched operands are not disturbed and no extra done pulse is generated.
REQ-021 SHALL hold diff, bout and ovf stable from completion until the next completion; intermediate bits are never visible on diff.
REQ-022 SHALL use a bit counter of width clog2(WIDTH)+1 that never wraps within an operation.
REQ-023 SHALL produce a result with total latency start-accept to done of WIDTH+1 edges, independent of operand values.

Reset
REQ-024 SHALL, while rst_n=0, immediately force: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, br=0, counter=0.
REQ-025 SHALL, if reset asserts mid-RUN, discard the operation with no done pulse; the first start after reset release is accepted normally.

Configuration
REQ-026 SHALL use the macro SERIAL_SUB_OVF_EN. When it is defined, ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), computed from the latched operands and updated together with diff. When it is undefined, the ovf port and its logic are absent, and all other behaviour is identical.

Verification
REQ-027 SHALL cover: WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; done high exactly 9 cycles after the start-accept edge; busy high for 8 cycles.
REQ-028 SHALL cover: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-029 SHALL cover: a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0; a second start issued in the done cycle completes 9 cycles later with the correct new result.
REQ-030 SHALL cover: start pulsed again at cycle 3 of RUN with different operands -> ignored; the original result is produced and there is a single done pulse.
REQ-031 SHALL cover: rst_n low at cycle 4 of RUN -> all outputs 0 immediately, no done pulse; a following start with a=0x09, b=0x04 -> diff=0x05.
REQ-032 SHALL cover, with SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; and a=0x05, b=0x03 -> ovf=0.
